mul_arbiter: RTL
================

# mul_arbiter

Shares the single 16-bit signed multiplier datapath between two requesters, for example the ALU execute stage and a coprocessor/graphics unit. Each requester has a valid/ready request channel and a valid/ready response channel. The block sequences one multiply at a time through a 3-state FSM and drives the multiplier's operand inputs from registers. The multiplier itself stays combinational and is instantiated outside this block.

## Interface
Parameters:
- WIDTH, 16, operand and result width (the multiplier's native width).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Req0Valid  in  1  requester 0 has an operand pair.
- Req0Ready  out  1  request 0 accepted this cycle.
- Req0A, Req0B  in  WIDTH  requester 0 signed operands.
- Resp0Valid  out  1  result for requester 0 on RespResult.
- Resp0Ready  in  1  requester 0 consumes the result.
- Req1Valid, Req1Ready, Req1A, Req1B, Resp1Valid, Resp1Ready: same as above, for requester 1.
- RespResult  out  WIDTH  result register; meaningful only while Resp0Valid or Resp1Valid is high.
- MulA, MulB  out  WIDTH  registered operands driven to the multiplier.
- MulResult  in  WIDTH  multiplier output: low WIDTH bits of the signed product.
- Busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states:
  - **IDLE**: choose a grantee among the valid requesters. Raise ReqNReady combinationally for the grantee only (ReqNReady = state==IDLE && grant==N && ReqNValid). On the handshake, load MulA/MulB from ReqNA/ReqNB, record the owner, and go to EXEC.
  - **EXEC**: load RespResult from MulResult, then go to RESP.
  - **RESP**: hold RespNValid=1 for the owner, with RespResult stable. When RespNReady=1, return to IDLE.
- The non-owner's Resp valid is always 0. Both Ready outputs are 0 outside IDLE.
- Arithmetic: signed two's complement. The result is the product truncated to WIDTH bits, with no saturation and no overflow flag.
- Both requesters valid in the same IDLE cycle: the winner is chosen by the arbitration policy (see Configuration).
- A request presented while the block is busy waits. ReqNValid must hold with stable operands until ReqNReady.
- RespNReady asserted outside RESP is ignored.
- Reset mid-operation: the in-flight operation is discarded and no response is issued.
- Reset values:
  - state IDLE;
  - MulA, MulB, RespResult = 0;
  - Req0Ready, Req1Ready, Resp0Valid, Resp1Valid, Busy = 0;
  - round-robin pointer favours requester 0.

## Timing
- Request handshake in cycle T. MulA/MulB are valid in T+1 (EXEC). RespResult and RespNValid are valid in T+2.
- Minimum occupancy is 3 cycles per operation (IDLE, EXEC, RESP with immediate RespReady). Peak throughput is 1 multiply per 3 cycles.
- Back-to-back: if RespNReady=1 in cycle T+2, the next grant can occur in T+3.
- The multiplier's combinational path (MulA/MulB to MulResult) must settle within one clk period.
- No combinational path from RespNReady to any output except through the state register.

## Configuration
- MUL_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - A 1-bit pointer names the preferred requester.
  - On each grant the pointer moves to the other requester.
  - Under continuous contention, grants strictly alternate.
- MUL_ARB_ROUND_ROBIN_EN undefined: fixed priority.
  - Requester 0 always wins a tie.
  - The pointer logic is removed.
  - Requester 1 is served only in IDLE cycles where Req0Valid=0.

## Test plan
- **Single op**:
  - Stimulus: Req0 with A=3, B=-4 (0xFFFC).
  - Response: Req0Ready at T, RespResult=0xFFF4 with Resp0Valid at T+2, Busy high for T+1..T+2.
- **Truncation**:
  - Stimulus: Req1 with A=300, B=300.
  - Response: RespResult=0x5F90. Separately, A=0x4000, B=4 gives 0x0000.
- **Contention**:
  - Stimulus: both requesters valid continuously with RespReady tied high, 6 ops.
  - Response with MUL_ARB_ROUND_ROBIN_EN: grant order 0,1,0,1,0,1.
  - Response without it: all 6 grants to requester 0.
- **Backpressure**:
  - Stimulus: Resp0Ready low for 5 cycles after Resp0Valid rises, with Req1Valid high throughout.
  - Response: Resp0Valid and RespResult stay stable, Req1Ready stays 0. Req1 is granted on the cycle after Resp0Ready goes high.
- **Reset mid-op**:
  - Stimulus: assert reset_n=0 during EXEC.
  - Response: all outputs are 0 immediately, with no clock edge needed. After release, state is IDLE, no stale response appears, and a new request completes normally.
- **Stable operands**:
  - Stimulus: change Req0A while Req0Valid is held but Req1 owns the multiplier.
  - Response: after the grant, the value latched into MulA is the value present at the Req0 handshake cycle.

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one external combinational signed multiplier between two requesters.
// Define MUL_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module mul_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [WIDTH-1:0] Req0A,
  input  logic [WIDTH-1:0] Req0B,
  output logic             Resp0Valid,
  input  logic             Resp0Ready,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [WIDTH-1:0] Req1A,
  input  logic [WIDTH-1:0] Req1B,
  output logic             Resp1Valid,
  input  logic             Resp1Ready,
  output logic [WIDTH-1:0] RespResult,
  output logic [WIDTH-1:0] MulA,
  output logic [WIDTH-1:0] MulB,
  input  logic [WIDTH-1:0] MulResult,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   grant;
  logic   idle;
  logic   take;
  logic   resp_ack;

`ifdef MUL_ARB_ROUND_ROBIN_EN
  logic ptr;

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (Req0Valid && Req1Valid):  grant = ptr;
      (Req1Valid && !Req0Valid): grant = 1'b1;
      default:                   grant = 1'b0;
    endcase
  end
`else
  // With nobody valid the grant value is irrelevant: both readies stay low.
  assign grant = !Req0Valid;
`endif

  // Readies are gated by reset so every output is low while reset is held.
  assign idle      = reset_n && (state == IDLE);
  assign Req0Ready = idle && !grant && Req0Valid;
  assign Req1Ready = idle &&  grant && Req1Valid;
  assign take      = Req0Ready || Req1Ready;
  assign resp_ack  = owner ? Resp1Ready : Resp0Ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      MulA       <= '0;
      MulB       <= '0;
      RespResult <= '0;
      Resp0Valid <= 1'b0;
      Resp1Valid <= 1'b0;
      Busy       <= 1'b0;
`ifdef MUL_ARB_ROUND_ROBIN_EN
      ptr        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            owner <= grant;
            MulA  <= grant ? Req1A : Req0A;
            MulB  <= grant ? Req1B : Req0B;
            Busy  <= 1'b1;
            state <= EXEC;
`ifdef MUL_ARB_ROUND_ROBIN_EN
            ptr   <= ~grant;
`endif
          end
        end
        EXEC: begin
          RespResult <= MulResult;
          Resp0Valid <= !owner;
          Resp1Valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ack) begin
            Resp0Valid <= 1'b0;
            Resp1Valid <= 1'b0;
            Busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          Resp0Valid <= 1'b0;
          Resp1Valid <= 1'b0;
          Busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  a_req_excl: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(Req0Ready && Req1Ready));

  a_resp_excl: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(Resp0Valid && Resp1Valid));

  a_busy: assert property (
    @(posedge clk) disable iff (!reset_n)
    Busy == (state != IDLE));

endmodule
